// File: rtl/alu_sequencer_pkg.sv
// Shared CPU definitions: ALU opcodes, bus sources, 8085 register indices,
// sequencer state and decoder result types. The ALU imports the same opcodes.
package cpu_defs;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_ADC = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_SBB = 5'd3;
  localparam logic [4:0] ALU_ANA = 5'd4;
  localparam logic [4:0] ALU_XRA = 5'd5;
  localparam logic [4:0] ALU_ORA = 5'd6;
  localparam logic [4:0] ALU_CMP = 5'd7;
  localparam logic [4:0] ALU_RLC = 5'd8;
  localparam logic [4:0] ALU_RRC = 5'd9;
  localparam logic [4:0] ALU_RAL = 5'd10;
  localparam logic [4:0] ALU_RAR = 5'd11;
  localparam logic [4:0] ALU_DAA = 5'd12;
  localparam logic [4:0] ALU_CMA = 5'd13;
  localparam logic [4:0] ALU_STC = 5'd14;
  localparam logic [4:0] ALU_CMC = 5'd15;
  localparam logic [4:0] ALU_INR = 5'd16;
  localparam logic [4:0] ALU_DCR = 5'd17;

  localparam logic [1:0] BUS_MEM  = 2'd0;
  localparam logic [1:0] BUS_REG  = 2'd1;
  localparam logic [1:0] BUS_ALU  = 2'd2;
  localparam logic [1:0] BUS_RSVD = 2'd3;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_M = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_HLT   = 8'h76;
  localparam logic [7:0] OP_MVI_A = 8'h3E;
  localparam logic [7:0] OP_INR_A = 8'h3C;
  localparam logic [7:0] OP_DCR_A = 8'h3D;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPERAND, S_REGRD, S_EXEC, S_HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_REG, CL_IMM, CL_MVI, CL_ACC, CL_HLT, CL_ILL
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    logic [4:0] alu_op;
    logic       uses_reg;
    logic [2:0] reg_idx;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Sequencer-facing bundle: program memory read port plus register-file and ALU control.
interface alu_sequencer_if;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       mem_rd;
  logic       pc_inc;
  logic [2:0] reg_sel;
  logic       reg_oe;
  logic [1:0] bus_src;
  logic [4:0] alu_opcode;
  logic       alu_ctrl;
  logic       alu_acc_we;
  logic       alu_tmp_we;
  logic       illegal;
  logic       halted;

  modport master (
    input  mem_data, mem_ready,
    output mem_rd, pc_inc, reg_sel, reg_oe, bus_src, alu_opcode,
           alu_ctrl, alu_acc_we, alu_tmp_we, illegal, halted
  );

  modport slave (
    output mem_data, mem_ready,
    input  mem_rd, pc_inc, reg_sel, reg_oe, bus_src, alu_opcode,
           alu_ctrl, alu_acc_we, alu_tmp_we, illegal, halted
  );
endinterface

// File: rtl/alu_sequencer_op_decoder.sv
// Combinational 8085 accumulator/arithmetic-group decoder: IR -> class, ALU op, register use.
module op_decoder
  import cpu_defs::*;
(
  input  logic [7:0] ir,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.cls      = CL_ILL;
    dec.alu_op   = ALU_ADD;
    dec.reg_idx  = ir[2:0];
    dec.illegal  = 1'b1;
    if (ir[7:6] == 2'b10) begin
      // Memory operand (M) needs an HL cycle this block does not sequence.
      if (ir[2:0] != REG_M) begin
        dec.cls      = CL_REG;
        dec.alu_op   = {2'b00, ir[5:3]};
        dec.uses_reg = (ir[2:0] != REG_A);
        dec.illegal  = 1'b0;
      end
    end else if (ir[7:6] == 2'b11 && ir[2:0] == 3'b110) begin
      dec.cls     = CL_IMM;
      dec.alu_op  = {2'b00, ir[5:3]};
      dec.illegal = 1'b0;
    end else if (ir[7:6] == 2'b00 && ir[2:0] == 3'b111) begin
      dec.cls     = CL_ACC;
      dec.alu_op  = {2'b01, ir[5:3]};
      dec.illegal = 1'b0;
    end else begin
      case (ir)
        OP_MVI_A: begin dec.cls = CL_MVI; dec.illegal = 1'b0; end
        OP_INR_A: begin dec.cls = CL_ACC; dec.alu_op = ALU_INR; dec.illegal = 1'b0; end
        OP_DCR_A: begin dec.cls = CL_ACC; dec.alu_op = ALU_DCR; dec.illegal = 1'b0; end
        OP_NOP:   begin dec.cls = CL_NOP; dec.illegal = 1'b0; end
        OP_HLT:   begin dec.cls = CL_HLT; dec.illegal = 1'b0; end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving the accumulator ALU, register file and
// program memory read port. Outputs are decoded from state and IR.
module alu_sequencer
  import cpu_defs::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.master bus
);

  seq_state_t state, state_nxt;
  logic [7:0] ir;
  logic [4:0] alu_op_q;
  dec_t       dec;

  logic       mem_rd, pc_inc, reg_oe, alu_ctrl, acc_we, tmp_we, illegal, halted;
  logic [2:0] reg_sel;
  logic [1:0] bus_src;

  op_decoder u_dec (.ir(ir), .dec(dec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      ir       <= '0;
      alu_op_q <= ALU_ADD;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.mem_ready)
        ir <= bus.mem_data;
      // Opcode is latched once and held through OPERAND/REGRD/EXEC and beyond.
      if (state == S_DECODE && (dec.cls == CL_REG || dec.cls == CL_IMM || dec.cls == CL_ACC))
        alu_op_q <= dec.alu_op;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    pc_inc    = 1'b0;
    reg_sel   = '0;
    reg_oe    = 1'b0;
    bus_src   = BUS_MEM;
    alu_ctrl  = 1'b0;
    acc_we    = 1'b0;
    tmp_we    = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (dec.cls)
          CL_REG:         state_nxt = S_REGRD;
          CL_IMM, CL_MVI: state_nxt = S_OPERAND;
          CL_ACC:         state_nxt = S_EXEC;
          CL_HLT:         state_nxt = S_HALT;
          CL_NOP:         state_nxt = S_FETCH;
          default: begin
            illegal   = dec.illegal;
            state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_OPERAND: begin
        mem_rd  = 1'b1;
        bus_src = BUS_MEM;
        if (bus.mem_ready) begin
          pc_inc = 1'b1;
          if (dec.cls == CL_MVI) begin
            acc_we    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            tmp_we    = 1'b1;
            state_nxt = S_EXEC;
          end
        end
      end
      S_REGRD: begin
        // Source A comes from the ALU output (tmp <= acc), not the register file.
        reg_sel   = dec.reg_idx;
        reg_oe    = dec.uses_reg;
        bus_src   = dec.uses_reg ? BUS_REG : BUS_ALU;
        tmp_we    = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_ctrl  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset masks every output so an in-flight read is dropped without a clock edge.
  assign bus.mem_rd     = mem_rd   & ~rst;
  assign bus.pc_inc     = pc_inc   & ~rst;
  assign bus.reg_sel    = rst ? '0 : reg_sel;
  assign bus.reg_oe     = reg_oe   & ~rst;
  assign bus.bus_src    = rst ? BUS_MEM : bus_src;
  assign bus.alu_opcode = rst ? ALU_ADD : alu_op_q;
  assign bus.alu_ctrl   = alu_ctrl & ~rst;
  assign bus.alu_acc_we = acc_we   & ~rst;
  assign bus.alu_tmp_we = tmp_we   & ~rst;
  assign bus.illegal    = illegal  & ~rst;
  assign bus.halted     = halted   & ~rst;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction sequencer that drives the accumulator ALU's control interface; it is the initiator for that interface, and the ALU is the responder.
- Fetches 8-bit 8085 opcodes and immediates over a ready-handshaked memory read port.
- Decodes the accumulator and arithmetic group, steers the internal 8-bit bus, and pulses the ALU load and execute strobes in the required order.
- Sits between the program memory/PC and the ALU plus register file in the CPU datapath.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = an unsupported opcode enters HALT; 0 = it executes as NOP.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst  in  1  asynchronous, active-high reset.
mem_data  in  8  opcode/immediate from program memory.
mem_ready  in  1  memory read complete; sampled only while mem_rd=1.
mem_rd  out  1  memory read request.
pc_inc  out  1  one-cycle PC increment pulse.
reg_sel  out  3  register-file index (8085 encoding: B=0, C, D, E, H, L).
reg_oe  out  1  register file drives the internal bus.
bus_src  out  2  bus source: 0=mem_data, 1=register file, 2=ALU out, 3=reserved.
alu_opcode  out  5  ALU operation code (ADD=0 … DCR=17, shared encoding).
alu_ctrl  out  1  ALU execute strobe.
alu_acc_we  out  1  ALU accumulator load from bus.
alu_tmp_we  out  1  ALU temp load from bus.
illegal  out  1  one-cycle pulse on an unsupported opcode.
halted  out  1  high in HALT state.

Behaviour:
- Reset: state=FETCH, IR=0x00, every output 0. Async reset mid-fetch drops mem_rd immediately; no pc_inc is issued for the aborted read.
- Outputs are decoded from state and IR. ALU act_store/act_restore are tied low at integration and are not driven by this block.
- States: FETCH, DECODE, OPERAND, REGRD, EXEC, HALT.
- FETCH:
  - mem_rd=1 until a posedge samples mem_ready=1.
  - In that cycle pc_inc=1 and IR<=mem_data; next state is DECODE.
  - Zero wait states gives a 1-cycle fetch. mem_ready seen while mem_rd=0 is ignored.
- DECODE (1 cycle, all strobes 0), next state by IR:
  - 0x80–0xBF (ADD/ADC/SUB/SBB/ANA/XRA/ORA/CMP r): alu_opcode=IR[5:3].
    - r=0..5 → REGRD.
    - r=7 (A) → REGRD with bus_src=2 (tmp<=acc).
    - r=6 (M) is unsupported → illegal handling.
  - Immediates 0xC6/CE/D6/DE/E6/EE/F6/FE: alu_opcode=IR[5:3] → OPERAND (tmp load).
  - 0x3E MVI A → OPERAND (acc load).
  - 0x07/0F/17/1F/27/2F/37/3F: alu_opcode=8+IR[5:3] (RLC…CMC) → EXEC.
  - 0x3C INR A → EXEC with opcode 16. 0x3D DCR A → EXEC with opcode 17.
  - 0x00 NOP → FETCH. 0x76 HLT → HALT.
  - Anything else: illegal=1 for this cycle; → HALT if HALT_ON_ILLEGAL, else → FETCH.
- OPERAND:
  - mem_rd=1 and bus_src=0 until mem_ready.
  - Accepting cycle: pc_inc=1, plus alu_tmp_we=1 (then → EXEC) or alu_acc_we=1 for MVI (then → FETCH).
- REGRD (1 cycle): reg_sel=IR[2:0], reg_oe=1 (0 when r=7), bus_src=1/2, alu_tmp_we=1 → EXEC.
- EXEC (1 cycle): alu_ctrl=1, alu_opcode held from decode, all other strobes 0 → FETCH.
- alu_opcode holds its last value outside EXEC. alu_ctrl, alu_tmp_we and alu_acc_we are never high in the same cycle.
- HALT: halted=1, mem_rd=0, all strobes 0. Only rst exits.
- Instruction latency with zero wait states:
  - register op: 4 cycles (FETCH, DECODE, REGRD, EXEC).
  - immediate op: 4 cycles. MVI: 3 cycles. single-byte accumulator op: 3 cycles. NOP: 2 cycles.
- Each wait cycle on mem_ready adds exactly one cycle and repeats no strobe.

Decomposition:
- Shared package (cpu_defs): ALU opcode localparams (ADD…DCR, 5 bits), bus_src encodings, 8085 register index constants, FSM state encoding. The ALU must use the same opcode constants.
- One natural sub-module: op_decoder. It is purely combinational, IR → {class, alu_opcode, uses_reg, reg index, illegal}.
- The sequencer FSM stays in alu_sequencer.

Test Plan:
- Memory returns 0x80 (ADD B) with mem_ready tied 1 → FETCH/DECODE/REGRD/EXEC: reg_sel=0 with reg_oe=1 and tmp_we=1 in cycle 3, alu_ctrl=1 with opcode=0 in cycle 4; one pc_inc.
- 0xFE 0x42 (CPI 42h) with 2 wait states per read → two pc_inc pulses; tmp_we coincides with the second accepting cycle, bus_src=0; then alu_ctrl=1 with opcode=7; total 8 cycles.
- 0x3E 0x55 (MVI A) → alu_acc_we=1 with bus_src=0 on the operand accept cycle, no alu_ctrl; back to FETCH after 3 cycles.
- 0x86 (ADD M) with HALT_ON_ILLEGAL=0 → illegal pulse in DECODE, no ALU strobes, next fetch follows. With HALT_ON_ILLEGAL=1 → halted=1 and held for 20 cycles.
- 0x76 (HLT) → halted=1, mem_rd stays 0; rst pulse → all outputs 0 asynchronously, fetch restarts.
- Assert rst while mem_rd=1 and mem_ready=0 → mem_rd=0 without waiting for a clock edge, no pc_inc; after release the first cycle is FETCH with mem_rd=1.
